vscale_hasti_arbiter: RTL and testbench

Two-master, one-slave HASTI (AHB-Lite) arbiter that lets the core's instruction-fetch bridge (m0) and data-memory bridge (m1) share one slave port.
- Selects the address-phase owner with fixed-priority or round-robin arbitration.
- Tracks the data-phase owner so read data, responses and write data reach the correct master.
- A per-master response hold buffer delivers a completed data phase correctly when that master's next address loses arbitration.

---
 rtl/vscale_hasti_arbiter_pkg.sv | 46 ++++
 rtl/vscale_hasti_arb_hold.sv | 44 ++++
 rtl/vscale_hasti_arbiter.sv | 171 +++++++++++++++++
 tb/tb_vscale_hasti_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_hasti_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vscale_hasti_arbiter_pkg
// Shared HASTI (AHB-Lite) constants and helpers for the two-master arbiter:
// bus widths, transfer/response/burst/protection encodings, the arbitration
// mode selectors and a master identifier type.
// -----------------------------------------------------------------------------
package vscale_hasti_arbiter_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_RESP_WIDTH  = 1;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'd1;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'd3;

  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY  = 1'b0;
  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_ERROR = 1'b1;

  localparam logic [HASTI_BURST_WIDTH-1:0] HASTI_BURST_SINGLE   = 3'd0;
  localparam logic                         HASTI_MASTER_NO_LOCK = 1'b0;
  localparam logic [HASTI_PROT_WIDTH-1:0]  HASTI_NO_PROT        = 4'd0;

  // Arbitration mode selectors for the ARB_MODE parameter.
  localparam int HASTI_ARB_FIXED = 0;
  localparam int HASTI_ARB_RR    = 1;

  typedef enum logic {
    MASTER_0 = 1'b0,
    MASTER_1 = 1'b1
  } master_e;

  function automatic master_e other_master(master_e m);
    return (m == MASTER_0) ? MASTER_1 : MASTER_0;
  endfunction

  function automatic logic is_request(logic [HASTI_TRANS_WIDTH-1:0] trans);
    return trans != HASTI_TRANS_IDLE;
  endfunction

endpackage

// File: rtl/vscale_hasti_arb_hold.sv
// -----------------------------------------------------------------------------
// vscale_hasti_arb_hold
// Per-master response hold buffer. Keeps the read data and response of a
// completed data phase whose master could not be told yet because its next
// address lost arbitration.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   capture         latch capture_data/capture_resp and mark valid
//   clear           drop the held response (master has taken it)
//   capture_data    slave read data to keep
//   capture_resp    slave response to keep
//   valid/data/resp held contents
// -----------------------------------------------------------------------------
module vscale_hasti_arb_hold
  import vscale_hasti_arbiter_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        capture,
  input  logic                        clear,
  input  logic [HASTI_BUS_WIDTH-1:0]  capture_data,
  input  logic [HASTI_RESP_WIDTH-1:0] capture_resp,
  output logic                        valid,
  output logic [HASTI_BUS_WIDTH-1:0]  data,
  output logic [HASTI_RESP_WIDTH-1:0] resp
);

  // Capture wins over clear; the arbiter never asserts both for one master
  // in the same cycle, so the order only matters for robustness.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
      resp  <= HASTI_RESP_OKAY;
    end else if (capture) begin
      valid <= 1'b1;
      data  <= capture_data;
      resp  <= capture_resp;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vscale_hasti_arbiter.sv
// -----------------------------------------------------------------------------
// vscale_hasti_arbiter
// Two-master, one-slave HASTI arbiter: m0 (instruction fetch) and m1 (data
// memory) share one slave port. The address-phase owner is chosen with fixed
// priority (m1 wins) or round robin; the data-phase owner is tracked so read
// data, responses and write data go to the right master.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   m0_*/m1_* inputs           master address phase and write data
//   m0_*/m1_* outputs          read data, ready and response per master
//   s_* outputs                muxed address phase, write data, constants
//   s_hrdata/s_hready/s_hresp  slave data-phase return
// -----------------------------------------------------------------------------
module vscale_hasti_arbiter
  import vscale_hasti_arbiter_pkg::*;
#(
  parameter int ARB_MODE = HASTI_ARB_RR
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [HASTI_ADDR_WIDTH-1:0]  m0_haddr,
  input  logic                         m0_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m0_hsize,
  input  logic [HASTI_TRANS_WIDTH-1:0] m0_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m0_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m0_hrdata,
  output logic                         m0_hready,
  output logic [HASTI_RESP_WIDTH-1:0]  m0_hresp,
  input  logic [HASTI_ADDR_WIDTH-1:0]  m1_haddr,
  input  logic                         m1_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m1_hsize,
  input  logic [HASTI_TRANS_WIDTH-1:0] m1_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m1_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m1_hrdata,
  output logic                         m1_hready,
  output logic [HASTI_RESP_WIDTH-1:0]  m1_hresp,
  output logic [HASTI_ADDR_WIDTH-1:0]  s_haddr,
  output logic                         s_hwrite,
  output logic [HASTI_SIZE_WIDTH-1:0]  s_hsize,
  output logic [HASTI_TRANS_WIDTH-1:0] s_htrans,
  output logic [HASTI_BURST_WIDTH-1:0] s_hburst,
  output logic                         s_hmastlock,
  output logic [HASTI_PROT_WIDTH-1:0]  s_hprot,
  output logic [HASTI_BUS_WIDTH-1:0]   s_hwdata,
  input  logic [HASTI_BUS_WIDTH-1:0]   s_hrdata,
  input  logic                         s_hready,
  input  logic [HASTI_RESP_WIDTH-1:0]  s_hresp
);

  master_e sel, sel_q, last_q, down_q;
  logic    dv_q;
  logic    req0, req1, accept;
  logic    own0, own1, addr_ok0, addr_ok1;
  logic    hready0, hready1, capture0, capture1;
  logic    hold_valid0, hold_valid1;
  logic [HASTI_BUS_WIDTH-1:0]  hold_data0, hold_data1;
  logic [HASTI_RESP_WIDTH-1:0] hold_resp0, hold_resp1;
  logic [HASTI_RESP_WIDTH-1:0] resp0, resp1;

  assign req0 = is_request(m0_htrans);
  assign req1 = is_request(m1_htrans);

  // Address owner. While the slave stretches a data phase the address phase
  // on the bus must not change, so the previous owner is kept. With nobody
  // requesting the bus parks on the last granted master.
  always_comb begin
    sel = sel_q;
    if (s_hready) begin
      if (req0 && !req1) begin
        sel = MASTER_0;
      end else if (req1 && !req0) begin
        sel = MASTER_1;
      end else if (req0 && req1) begin
        sel = (ARB_MODE == HASTI_ARB_RR) ? other_master(last_q) : MASTER_1;
      end else begin
        sel = last_q;
      end
    end
  end

  assign accept = s_hready && ((sel == MASTER_0) ? req0 : req1);

  // Arbitration and data-phase tracking state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q  <= MASTER_0;
      last_q <= MASTER_0;
      dv_q   <= 1'b0;
      down_q <= MASTER_0;
    end else begin
      sel_q <= sel;
      if (accept) begin
        dv_q   <= 1'b1;
        down_q <= sel;
        last_q <= sel;
      end else if (s_hready) begin
        dv_q <= 1'b0;
      end
    end
  end

  // Address phase straight from the owner, no added latency; reset forces
  // an IDLE transfer so the slave never sees a stray request.
  always_comb begin
    s_haddr  = (sel == MASTER_0) ? m0_haddr  : m1_haddr;
    s_hwrite = (sel == MASTER_0) ? m0_hwrite : m1_hwrite;
    s_hsize  = (sel == MASTER_0) ? m0_hsize  : m1_hsize;
    s_htrans = HASTI_TRANS_IDLE;
    if (reset) begin
      s_htrans = (sel == MASTER_0) ? m0_htrans : m1_htrans;
    end
  end

  assign s_hburst    = HASTI_BURST_SINGLE;
  assign s_hmastlock = HASTI_MASTER_NO_LOCK;
  assign s_hprot     = HASTI_NO_PROT;

  assign s_hwdata = !dv_q ? '0 : ((down_q == MASTER_0) ? m0_hwdata : m1_hwdata);

  // A master's address is "ok" when it is idle or currently owns the bus.
  // When its data phase completes but its next address lost, the result is
  // parked in the hold buffer and hready stays low until it wins.
  assign own0     = dv_q && (down_q == MASTER_0);
  assign own1     = dv_q && (down_q == MASTER_1);
  assign addr_ok0 = !req0 || (sel == MASTER_0);
  assign addr_ok1 = !req1 || (sel == MASTER_1);

  assign hready0 = hold_valid0 ? (!req0 || ((sel == MASTER_0) && s_hready))
                               : (s_hready && addr_ok0);
  assign hready1 = hold_valid1 ? (!req1 || ((sel == MASTER_1) && s_hready))
                               : (s_hready && addr_ok1);

  assign capture0 = own0 && s_hready && !addr_ok0;
  assign capture1 = own1 && s_hready && !addr_ok1;

  assign resp0 = hold_valid0 ? hold_resp0 : (own0 ? s_hresp : HASTI_RESP_OKAY);
  assign resp1 = hold_valid1 ? hold_resp1 : (own1 ? s_hresp : HASTI_RESP_OKAY);

  vscale_hasti_arb_hold u_hold0 (
    .clk          (clk),
    .reset        (reset),
    .capture      (capture0),
    .clear        (hready0),
    .capture_data (s_hrdata),
    .capture_resp (s_hresp),
    .valid        (hold_valid0),
    .data         (hold_data0),
    .resp         (hold_resp0)
  );

  vscale_hasti_arb_hold u_hold1 (
    .clk          (clk),
    .reset        (reset),
    .capture      (capture1),
    .clear        (hready1),
    .capture_data (s_hrdata),
    .capture_resp (s_hresp),
    .valid        (hold_valid1),
    .data         (hold_data1),
    .resp         (hold_resp1)
  );

  // During reset both masters see an idle, OKAY bus.
  assign m0_hready = !reset ? 1'b1 : hready0;
  assign m1_hready = !reset ? 1'b1 : hready1;
  assign m0_hresp  = !reset ? HASTI_RESP_OKAY : resp0;
  assign m1_hresp  = !reset ? HASTI_RESP_OKAY : resp1;
  assign m0_hrdata = hold_valid0 ? hold_data0 : s_hrdata;
  assign m1_hrdata = hold_valid1 ? hold_data1 : s_hrdata;

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vscale_hasti_arbiter
// Directed scenarios for arbitration, hold buffer, ERROR and reset, then a
// randomized run: two AHB master agents and a wait-stating memory slave, with
// expected read data/responses taken from a reference memory per master.
// -----------------------------------------------------------------------------
module tb_vscale_hasti_arbiter;
  import vscale_hasti_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata;
  logic        m0_hwrite, m1_hwrite, m0_hready, m1_hready;
  logic [2:0]  m0_hsize, m1_hsize, s_hsize, s_hburst;
  logic [1:0]  m0_htrans, m1_htrans, s_htrans;
  logic [0:0]  m0_hresp, m1_hresp, s_hresp;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hwrite, s_hmastlock, s_hready;
  logic [3:0]  s_hprot;

  int total = 0;
  int bad = 0;

  vscale_hasti_arbiter #(.ARB_MODE(1)) dut (
    .clk(clk), .reset(reset),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_htrans(m0_htrans), .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata),
    .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_htrans(m1_htrans), .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata),
    .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_htrans(s_htrans), .s_hburst(s_hburst), .s_hmastlock(s_hmastlock),
    .s_hprot(s_hprot), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
    .s_hready(s_hready), .s_hresp(s_hresp)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NSEQ = 2'd2;
  localparam logic [0:0] OK   = 1'b0;
  localparam logic [0:0] ERR  = 1'b1;

  // Scoreboard entry: what a master must see when its data phase completes.
  typedef struct packed {
    logic        write;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Master agent state (address phase and data phase).
  logic        a_valid[2];
  logic [31:0] a_addr[2];
  logic        a_write[2];
  logic [31:0] a_wdata[2];
  logic        dp_active[2];
  logic        dp_next[2];
  logic [31:0] d_wdata[2];
  logic [31:0] d_wdata_next[2];
  int          stall[2];
  logic        issue_en;
  logic        rand_on = 1'b0;

  // Slave model state and memories (slave-side and reference).
  logic        sd_active, sd_write, sd_err, sd_errstage;
  logic [31:0] sd_addr;
  int          sd_wait;
  logic [31:0] sm[128];
  logic [31:0] rm[128];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_m(input int i, input logic [1:0] tr, input logic [31:0] ad,
                       input logic wr, input logic [31:0] wd);
    if (i == 0) begin
      m0_htrans = tr; m0_haddr = ad; m0_hwrite = wr; m0_hwdata = wd; m0_hsize = 3'd2;
    end else begin
      m1_htrans = tr; m1_haddr = ad; m1_hwrite = wr; m1_hwdata = wd; m1_hsize = 3'd2;
    end
  endtask

  task automatic set_s(input logic rdy, input logic [31:0] rd, input logic [0:0] rsp);
    s_hready = rdy; s_hrdata = rd; s_hresp = rsp;
  endtask

  task automatic cycle_start();
    @(posedge clk);
    #1;
  endtask

  task automatic new_txn(input int i);
    a_valid[i] = issue_en && ($urandom_range(0, 3) != 0);
    a_addr[i]  = ((i == 0) ? 32'h000 : 32'h100) + ($urandom_range(0, 7) << 2);
    a_write[i] = 1'($urandom_range(0, 1));
    a_wdata[i] = $urandom;
  endtask

  task automatic push_exp(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // One master's view of a clock edge: hready ends its data phase and, if it
  // had an address up, turns that address into the next data phase.
  task automatic master_step(input int i, input logic hr);
    exp_t       e;
    logic [6:0] idx;
    if (hr) begin
      dp_next[i] = 1'b0;
      d_wdata_next[i] = d_wdata[i];
      if (a_valid[i]) begin
        idx     = a_addr[i][8:2];
        e.write = a_write[i];
        e.err   = (a_addr[i][4:2] == 3'd7);
        e.rdata = rm[idx];
        if (e.write && !e.err) rm[idx] = a_wdata[i];
        push_exp(i, e);
        dp_next[i] = 1'b1;
        d_wdata_next[i] = a_wdata[i];
      end
      new_txn(i);
      stall[i] = 0;
    end else begin
      dp_next[i] = dp_active[i];
      d_wdata_next[i] = d_wdata[i];
      if (a_valid[i] || dp_active[i]) stall[i]++;
      if (stall[i] == 60) begin
        total++;
        bad++;
        $display("[TB] FAIL stall_m%0d actual=%0d cycles expected=<60", i, stall[i]);
      end
    end
  endtask

  // One random cycle: drive masters and slave after the edge, then observe.
  task automatic apply_stimulus();
    cycle_start();
    for (int i = 0; i < 2; i++) begin
      dp_active[i] = dp_next[i];
      d_wdata[i]   = d_wdata_next[i];
    end
    for (int i = 0; i < 2; i++)
      set_m(i, a_valid[i] ? NSEQ : IDLE, a_addr[i], a_write[i], d_wdata[i]);
    if (sd_active) begin
      if (sd_err) set_s(sd_errstage, $urandom, ERR);
      else set_s(sd_wait == 0, sd_write ? $urandom : sm[sd_addr[8:2]], OK);
    end else begin
      set_s(1'b1, $urandom, OK);
    end
    @(negedge clk);
    if (sd_active && s_hready) begin
      if (sd_write && !sd_err) sm[sd_addr[8:2]] = s_hwdata;
      sd_active = 1'b0;
    end else if (sd_active) begin
      if (sd_err) sd_errstage = 1'b1;
      else sd_wait--;
    end
    if (s_hready && s_htrans != IDLE) begin
      sd_active   = 1'b1;
      sd_addr     = s_haddr;
      sd_write    = s_hwrite;
      sd_err      = (s_haddr[4:2] == 3'd7);
      sd_errstage = 1'b0;
      sd_wait     = $urandom_range(0, 2);
    end
    master_step(0, m0_hready);
    master_step(1, m1_hready);
  endtask

  task automatic mon_master(input int i, input logic hr, input logic [0:0] resp,
                            input logic [31:0] rdata);
    exp_t e;
    if (!dp_active[i]) begin
      check_output($sformatf("m%0d_idle_resp", i), 32'(resp), 32'(OK));
    end else if (hr) begin
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        total++;
        bad++;
        $display("[TB] FAIL m%0d_sb_empty actual=completion expected=none", i);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        check_output($sformatf("m%0d_resp", i), 32'(resp), e.err ? 32'(ERR) : 32'(OK));
        if (!e.write && !e.err)
          check_output($sformatf("m%0d_rdata", i), rdata, e.rdata);
      end
    end
  endtask

  // Monitor: compares completed data phases against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rand_on) begin
        mon_master(0, m0_hready, m0_hresp, m0_hrdata);
        mon_master(1, m1_hready, m1_hresp, m1_hrdata);
      end
    end
  end

  initial begin
    reset = 1'b0;
    set_m(0, IDLE, 0, 0, 0);
    set_m(1, IDLE, 0, 0, 0);
    set_s(1'b1, 0, OK);
    for (int k = 0; k < 128; k++) begin
      sm[k] = {16'hA5C3, 16'(k)};
      rm[k] = {16'hA5C3, 16'(k)};
    end

    // Reset forces an idle, ready, OKAY bus even with a master requesting.
    cycle_start(); set_m(0, NSEQ, 32'h100, 0, 0);
    @(negedge clk);
    check_output("rst_htrans", 32'(s_htrans), 32'(IDLE));
    check_output("rst_m0_hready", 32'(m0_hready), 1);
    check_output("rst_m1_hready", 32'(m1_hready), 1);
    check_output("rst_m1_hresp", 32'(m1_hresp), 32'(OK));

    // Single m0 read, zero-wait slave.
    cycle_start(); reset = 1'b1; set_m(0, NSEQ, 32'h100, 0, 0);
    @(negedge clk);
    check_output("t1_haddr", s_haddr, 32'h100);
    check_output("t1_htrans", 32'(s_htrans), 32'(NSEQ));
    check_output("t1_m0_hready", 32'(m0_hready), 1);
    cycle_start(); set_m(0, IDLE, 32'h100, 0, 0); set_s(1'b1, 32'hDEADBEEF, OK);
    @(negedge clk);
    check_output("t1_m0_hrdata", m0_hrdata, 32'hDEADBEEF);
    check_output("t1_m1_hready", 32'(m1_hready), 1);

    // Contention right after reset: round robin starts with m1.
    cycle_start(); reset = 1'b0; set_m(0, IDLE, 0, 0, 0);
    @(negedge clk);
    cycle_start(); reset = 1'b1;
    set_m(0, NSEQ, 32'h010, 0, 0); set_m(1, NSEQ, 32'h020, 0, 0); set_s(1'b1, 0, OK);
    @(negedge clk);
    check_output("t2_haddr", s_haddr, 32'h020);
    check_output("t2_m0_hready", 32'(m0_hready), 0);
    check_output("t2_m1_hready", 32'(m1_hready), 1);
    cycle_start(); set_m(1, IDLE, 32'h020, 0, 0); set_s(1'b1, 32'h22, OK);
    @(negedge clk);
    check_output("t2_haddr2", s_haddr, 32'h010);
    check_output("t2_m0_hready2", 32'(m0_hready), 1);
    check_output("t2_m1_hrdata", m1_hrdata, 32'h22);
    cycle_start(); set_m(0, IDLE, 32'h010, 0, 0); set_s(1'b1, 32'h33, OK);
    @(negedge clk);
    check_output("t2_m0_hrdata", m0_hrdata, 32'h33);

    // m1 back-to-back reads losing to m0: response goes through the hold.
    cycle_start(); set_m(0, NSEQ, 32'h040, 0, 0); set_m(1, NSEQ, 32'h200, 0, 0); set_s(1'b1, 0, OK);
    @(negedge clk);
    check_output("t3_haddr1", s_haddr, 32'h200);
    cycle_start(); set_m(1, NSEQ, 32'h204, 0, 0); set_s(1'b1, 32'h11, OK);
    @(negedge clk);
    check_output("t3_haddr2", s_haddr, 32'h040);
    check_output("t3_m1_hready2", 32'(m1_hready), 0);
    check_output("t3_m0_hready2", 32'(m0_hready), 1);
    cycle_start(); set_m(0, IDLE, 32'h040, 0, 0); set_s(1'b1, 32'h44, OK);
    @(negedge clk);
    check_output("t3_m1_hready3", 32'(m1_hready), 1);
    check_output("t3_m1_hrdata3", m1_hrdata, 32'h11);
    check_output("t3_haddr3", s_haddr, 32'h204);
    check_output("t3_m0_hrdata3", m0_hrdata, 32'h44);
    cycle_start(); set_m(1, IDLE, 32'h204, 0, 0); set_s(1'b1, 32'h55, OK);
    @(negedge clk);
    check_output("t3_m1_hrdata4", m1_hrdata, 32'h55);

    // Wait-stated m0 data phase keeps the address phase on m0.
    cycle_start(); set_m(0, NSEQ, 32'h060, 0, 0); set_s(1'b1, 0, OK);
    @(negedge clk);
    check_output("t4_haddr", s_haddr, 32'h060);
    for (int k = 0; k < 3; k++) begin
      cycle_start(); set_m(0, IDLE, 32'h060, 0, 0); set_m(1, NSEQ, 32'h070, 0, 0); set_s(1'b0, 0, OK);
      @(negedge clk);
      check_output($sformatf("t4_stall%0d_haddr", k), s_haddr, 32'h060);
      check_output($sformatf("t4_stall%0d_m1_hready", k), 32'(m1_hready), 0);
    end
    cycle_start(); set_s(1'b1, 32'h66, OK);
    @(negedge clk);
    check_output("t4_haddr_m1", s_haddr, 32'h070);
    check_output("t4_m1_hready", 32'(m1_hready), 1);
    check_output("t4_m0_hrdata", m0_hrdata, 32'h66);
    cycle_start(); set_m(1, IDLE, 32'h070, 0, 0); set_s(1'b1, 0, OK);
    @(negedge clk);

    // Two-cycle ERROR on an m1 write.
    cycle_start(); set_m(1, NSEQ, 32'h300, 1, 0);
    @(negedge clk);
    check_output("t5_haddr", s_haddr, 32'h300);
    cycle_start(); set_m(1, IDLE, 32'h300, 1, 32'hCAFEF00D); set_s(1'b0, 0, ERR);
    @(negedge clk);
    check_output("t5_m1_hresp1", 32'(m1_hresp), 32'(ERR));
    check_output("t5_m1_hready1", 32'(m1_hready), 0);
    check_output("t5_m0_hresp1", 32'(m0_hresp), 32'(OK));
    check_output("t5_hwdata", s_hwdata, 32'hCAFEF00D);
    cycle_start(); set_s(1'b1, 0, ERR);
    @(negedge clk);
    check_output("t5_m1_hresp2", 32'(m1_hresp), 32'(ERR));
    check_output("t5_m1_hready2", 32'(m1_hready), 1);
    check_output("t5_m0_hresp2", 32'(m0_hresp), 32'(OK));
    cycle_start(); set_s(1'b1, 0, OK);
    @(negedge clk);
    check_output("t5_m1_hresp3", 32'(m1_hresp), 32'(OK));

    // Reset during a wait-stated m1 read; arbitration history is lost.
    cycle_start(); set_m(1, NSEQ, 32'h400, 0, 0);
    @(negedge clk);
    check_output("t6_haddr", s_haddr, 32'h400);
    cycle_start(); reset = 1'b0;
    set_m(0, NSEQ, 32'h500, 0, 0); set_m(1, NSEQ, 32'h404, 0, 0); set_s(1'b0, 0, OK);
    @(negedge clk);
    check_output("t6_rst_htrans", 32'(s_htrans), 32'(IDLE));
    check_output("t6_rst_m0_hready", 32'(m0_hready), 1);
    check_output("t6_rst_m1_hready", 32'(m1_hready), 1);
    cycle_start(); reset = 1'b1; set_s(1'b1, 0, OK);
    @(negedge clk);
    check_output("t6_grant_haddr", s_haddr, 32'h404);
    check_output("t6_m0_hready", 32'(m0_hready), 0);
    check_output("t6_m1_hready", 32'(m1_hready), 1);

    // Randomized run from a clean reset.
    cycle_start(); reset = 1'b0; set_m(0, IDLE, 0, 0, 0); set_m(1, IDLE, 0, 0, 0);
    @(negedge clk);
    cycle_start(); reset = 1'b1;
    @(negedge clk);
    sd_active = 1'b0; sd_write = 1'b0; sd_err = 1'b0; sd_errstage = 1'b0;
    sd_addr = 0; sd_wait = 0;
    issue_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dp_next[i] = 1'b0; dp_active[i] = 1'b0;
      d_wdata_next[i] = 0; d_wdata[i] = 0; stall[i] = 0;
      new_txn(i);
    end
    rand_on = 1'b1;
    for (int n = 0; n < 1500; n++) apply_stimulus();
    issue_en = 1'b0;
    for (int n = 0; n < 40; n++) apply_stimulus();
    #2;
    rand_on = 1'b0;
    check_output("drain_q0", q0.size(), 0);
    check_output("drain_q1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
